// File: rtl/pb_i2c_poller_pkg.sv
// Shared definitions for the I2C poller: transaction types, FSM states,
// the constant poll table and small data-packing helpers.
package pb_i2c_poller_pkg;

    localparam int N_POLL_DEF   = 4;
    localparam int POLL_TBL_MAX = 8;

    localparam logic [3:0] TT_WRITE   = 4'd0;
    localparam logic [3:0] TT_READ2   = 4'd1;
    localparam logic [3:0] TT_RSREAD1 = 4'd2;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_BUSY,
        ST_CAPTURE
    } state_e;

    typedef struct packed {
        logic [3:0] ttype;
        logic [7:0] addr;
        logic [7:0] regn;
    } poll_ent_t;

    // Fixed poll table; only read types appear here.
    function automatic poll_ent_t poll_entry(input logic [2:0] k);
        poll_ent_t e;
        case (k)
            3'd0:    e = '{ttype: TT_READ2,   addr: 8'h48, regn: 8'h00};
            3'd1:    e = '{ttype: TT_RSREAD1, addr: 8'h49, regn: 8'h10};
            3'd2:    e = '{ttype: TT_READ2,   addr: 8'h4A, regn: 8'h20};
            3'd3:    e = '{ttype: TT_RSREAD1, addr: 8'h4B, regn: 8'h30};
            3'd4:    e = '{ttype: TT_READ2,   addr: 8'h4C, regn: 8'h40};
            3'd5:    e = '{ttype: TT_RSREAD1, addr: 8'h4D, regn: 8'h50};
            3'd6:    e = '{ttype: TT_READ2,   addr: 8'h4E, regn: 8'h60};
            default: e = '{ttype: TT_RSREAD1, addr: 8'h4F, regn: 8'h70};
        endcase
        return e;
    endfunction

    // A single-byte read leaves the upper byte zero.
    function automatic logic [15:0] pack_rd(input logic [3:0] t,
                                            input logic [7:0] rd0,
                                            input logic [7:0] rd1);
        return (t == TT_RSREAD1) ? {8'h00, rd0} : {rd1, rd0};
    endfunction

endpackage

// File: rtl/pb_poll_timer.sv
// Poll period counter: raises round_pending_o on each period expiry and
// flags err_overrun_o when an expiry lands on a round still in progress.
// Ports: clk/reset, enable_i, period_i, round_start_i (consume pending),
// round_active_i, round_pending_o, err_overrun_o (sticky).
module pb_poll_timer (
    input  logic        clk,
    input  logic        reset,
    input  logic        enable_i,
    input  logic [23:0] period_i,
    input  logic        round_start_i,
    input  logic        round_active_i,
    output logic        round_pending_o,
    output logic        err_overrun_o
);

    logic [23:0] cnt_q, cnt_d;
    logic        pend_q, pend_d;
    logic        ovr_q, ovr_d;
    logic        run;
    logic        expire;

    assign run    = enable_i && (period_i != 24'd0);
    // >= keeps the counter from running away if period shrinks mid-count.
    assign expire = run && (cnt_q >= period_i - 24'd1);

    always_comb begin
        cnt_d  = 24'd0;
        pend_d = pend_q;
        ovr_d  = ovr_q;
        if (run && !expire) begin
            cnt_d = cnt_q + 24'd1;
        end
        if (round_start_i || !run) begin
            pend_d = 1'b0;
        end
        // An expiry on a round still waiting or running is dropped.
        if (expire) begin
            if (pend_q || round_active_i) begin
                ovr_d = 1'b1;
            end else begin
                pend_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q  <= 24'd0;
            pend_q <= 1'b0;
            ovr_q  <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            pend_q <= pend_d;
            ovr_q  <= ovr_d;
        end
    end

    assign round_pending_o = pend_q;
    assign err_overrun_o   = ovr_q;

endmodule

// File: rtl/pb_i2c_poller.sv
// I2C poller: arbitrates host transactions and periodic poll-table reads
// onto one transaction engine (start/status handshake), stores results.
// Ports: clk/reset, enable/period (polling), host_* (request/result),
// i2c_* (engine side), poll_data/poll_valid/round_done, err_tmo/err_overrun.
module pb_i2c_poller
    import pb_i2c_poller_pkg::*;
#(
    parameter int N_POLL    = N_POLL_DEF,
    parameter int ISSUE_TMO = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 enable,
    input  logic [23:0]          period,
    input  logic                 host_req,
    input  logic [3:0]           host_type,
    input  logic [7:0]           host_addr,
    input  logic [7:0]           host_reg,
    input  logic [7:0]           host_wr0,
    input  logic [7:0]           host_wr1,
    output logic                 host_busy,
    output logic                 host_done,
    output logic [7:0]           host_rd0,
    output logic [7:0]           host_rd1,
    output logic                 i2c_start,
    output logic [3:0]           i2c_type,
    output logic [7:0]           i2c_addr,
    output logic [7:0]           i2c_reg,
    output logic [7:0]           i2c_wr_data0,
    output logic [7:0]           i2c_wr_data1,
    input  logic                 i2c_status,
    input  logic [7:0]           i2c_rd_data0,
    input  logic [7:0]           i2c_rd_data1,
    output logic [16*N_POLL-1:0] poll_data,
    output logic [N_POLL-1:0]    poll_valid,
    output logic                 round_done,
    output logic                 err_tmo,
    output logic                 err_overrun
);

    localparam int IDX_W = (N_POLL > 1) ? $clog2(N_POLL) : 1;
    localparam int TMO_W = (ISSUE_TMO > 1) ? $clog2(ISSUE_TMO) : 1;

    state_e              state_q;
    logic                busy_q;
    logic [3:0]          hq_type_q;
    logic [7:0]          hq_addr_q;
    logic [7:0]          hq_reg_q;
    logic [7:0]          hq_wr0_q;
    logic [7:0]          hq_wr1_q;
    logic                cur_host_q;
    logic                round_act_q;
    logic [IDX_W-1:0]    idx_q;
    logic [TMO_W-1:0]    tmo_q;
    logic                done_q;
    logic [7:0]          rd0_q;
    logic [7:0]          rd1_q;
    logic                start_q;
    logic [3:0]          type_q;
    logic [7:0]          addr_q;
    logic [7:0]          reg_q;
    logic [7:0]          wr0_q;
    logic [7:0]          wr1_q;
    logic [16*N_POLL-1:0] pdata_q;
    logic [N_POLL-1:0]   pvalid_q;
    logic                rdone_q;
    logic                etmo_q;

    logic                round_pending;
    logic                round_start;
    logic [IDX_W-1:0]    nxt_idx;
    poll_ent_t           nxt_ent;
    logic                last_ent;

    // A new round starts only when no host request is waiting.
    assign round_start = (state_q == ST_IDLE) && !busy_q &&
                         !round_act_q && round_pending;
    assign nxt_idx     = round_act_q ? idx_q : '0;
    assign nxt_ent     = poll_entry(3'(nxt_idx));
    assign last_ent    = (idx_q == IDX_W'(N_POLL - 1));

    pb_poll_timer u_timer (
        .clk             (clk),
        .reset           (reset),
        .enable_i        (enable),
        .period_i        (period),
        .round_start_i   (round_start),
        .round_active_i  (round_act_q),
        .round_pending_o (round_pending),
        .err_overrun_o   (err_overrun)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            busy_q      <= 1'b0;
            hq_type_q   <= 4'd0;
            hq_addr_q   <= 8'd0;
            hq_reg_q    <= 8'd0;
            hq_wr0_q    <= 8'd0;
            hq_wr1_q    <= 8'd0;
            cur_host_q  <= 1'b0;
            round_act_q <= 1'b0;
            idx_q       <= '0;
            tmo_q       <= '0;
            done_q      <= 1'b0;
            rd0_q       <= 8'd0;
            rd1_q       <= 8'd0;
            start_q     <= 1'b0;
            type_q      <= 4'd0;
            addr_q      <= 8'd0;
            reg_q       <= 8'd0;
            wr0_q       <= 8'd0;
            wr1_q       <= 8'd0;
            pdata_q     <= '0;
            pvalid_q    <= '0;
            rdone_q     <= 1'b0;
            etmo_q      <= 1'b0;
        end else begin
            done_q  <= 1'b0;
            rdone_q <= 1'b0;

            if (host_req && !busy_q) begin
                busy_q    <= 1'b1;
                hq_type_q <= host_type;
                hq_addr_q <= host_addr;
                hq_reg_q  <= host_reg;
                hq_wr0_q  <= host_wr0;
                hq_wr1_q  <= host_wr1;
            end

            unique case (state_q)
                ST_IDLE: begin
                    if (busy_q) begin
                        cur_host_q <= 1'b1;
                        type_q     <= hq_type_q;
                        addr_q     <= hq_addr_q;
                        reg_q      <= hq_reg_q;
                        wr0_q      <= hq_wr0_q;
                        wr1_q      <= hq_wr1_q;
                        start_q    <= 1'b1;
                        tmo_q      <= '0;
                        state_q    <= ST_ISSUE;
                    end else if (round_act_q || round_pending) begin
                        round_act_q <= 1'b1;
                        idx_q       <= nxt_idx;
                        cur_host_q  <= 1'b0;
                        type_q      <= nxt_ent.ttype;
                        addr_q      <= nxt_ent.addr;
                        reg_q       <= nxt_ent.regn;
                        wr0_q       <= 8'd0;
                        wr1_q       <= 8'd0;
                        start_q     <= 1'b1;
                        tmo_q       <= '0;
                        state_q     <= ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    if (i2c_status) begin
                        start_q <= 1'b0;
                        state_q <= ST_BUSY;
                    end else if (tmo_q == TMO_W'(ISSUE_TMO - 1)) begin
                        // Engine never answered: abandon this transaction.
                        start_q <= 1'b0;
                        etmo_q  <= 1'b1;
                        state_q <= ST_IDLE;
                        if (cur_host_q) begin
                            done_q <= 1'b1;
                            busy_q <= 1'b0;
                        end else if (last_ent) begin
                            round_act_q <= 1'b0;
                            rdone_q     <= 1'b1;
                        end else begin
                            idx_q <= idx_q + 1'b1;
                        end
                    end else begin
                        tmo_q <= tmo_q + 1'b1;
                    end
                end
                ST_BUSY: begin
                    if (!i2c_status) begin
                        state_q <= ST_CAPTURE;
                        if (cur_host_q) begin
                            rd0_q  <= i2c_rd_data0;
                            rd1_q  <= i2c_rd_data1;
                            done_q <= 1'b1;
                            busy_q <= 1'b0;
                        end else begin
                            pdata_q[16*int'(idx_q) +: 16] <=
                                pack_rd(type_q, i2c_rd_data0, i2c_rd_data1);
                            pvalid_q[idx_q] <= 1'b1;
                        end
                    end
                end
                ST_CAPTURE: begin
                    state_q <= ST_IDLE;
                    if (!cur_host_q) begin
                        if (last_ent) begin
                            round_act_q <= 1'b0;
                            rdone_q     <= 1'b1;
                        end else begin
                            idx_q <= idx_q + 1'b1;
                        end
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign host_busy    = busy_q;
    assign host_done    = done_q;
    assign host_rd0     = rd0_q;
    assign host_rd1     = rd1_q;
    assign i2c_start    = start_q;
    assign i2c_type     = type_q;
    assign i2c_addr     = addr_q;
    assign i2c_reg      = reg_q;
    assign i2c_wr_data0 = wr0_q;
    assign i2c_wr_data1 = wr1_q;
    assign poll_data    = pdata_q;
    assign poll_valid   = pvalid_q;
    assign round_done   = rdone_q;
    assign err_tmo      = etmo_q;

endmodule
